// File: rtl/cal_uart_rx.sv
// UART 8N1 receiver plus 5-byte calibration packet decoder:
// SYNC, addr, data_hi, data_lo, xor checksum -> single-cycle register write strobe.
module cal_uart_rx #(
   parameter int unsigned CLK_DIV   = 12,
   parameter int unsigned TIMEOUT   = 12000,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        clk_12mhz,
   input  logic        rst,
   input  logic        rx_i,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        frame_err,
   output logic        cal_we,
   output logic [2:0]  cal_addr,
   output logic [15:0] cal_data,
   output logic        pkt_err
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} bit_state_t;
   typedef enum logic [2:0] {P_SYNC, P_ADDR, P_DHI, P_DLO, P_CSUM} pkt_state_t;

   logic [1:0]       sync;
   logic             rx;
   bit_state_t       bstate, bstate_n;
   logic [CNT_W-1:0] bcnt, bcnt_n;
   logic [2:0]       bidx, bidx_n;
   logic [7:0]       shift, shift_n;
   logic             valid_n, ferr_n;
   logic [7:0]       data_n;

   pkt_state_t       pstate, pstate_n;
   logic [2:0]       addr_q, addr_n;
   logic [7:0]       dhi, dhi_n, dlo, dlo_n;
   logic [TO_W-1:0]  tcnt, tcnt_n;
   logic             we_n, perr_n;
   logic [2:0]       cal_addr_n;
   logic [15:0]      cal_data_n;

   assign rx = sync[1];

   // State and registered outputs
   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         sync       <= 2'b11;
         bstate     <= B_IDLE;
         bcnt       <= '0;
         bidx       <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
         pstate     <= P_SYNC;
         addr_q     <= '0;
         dhi        <= '0;
         dlo        <= '0;
         tcnt       <= '0;
         cal_we     <= 1'b0;
         cal_addr   <= '0;
         cal_data   <= '0;
         pkt_err    <= 1'b0;
      end else begin
         sync       <= {sync[0], rx_i};
         bstate     <= bstate_n;
         bcnt       <= bcnt_n;
         bidx       <= bidx_n;
         shift      <= shift_n;
         byte_valid <= valid_n;
         byte_data  <= data_n;
         frame_err  <= ferr_n;
         pstate     <= pstate_n;
         addr_q     <= addr_n;
         dhi        <= dhi_n;
         dlo        <= dlo_n;
         tcnt       <= tcnt_n;
         cal_we     <= we_n;
         cal_addr   <= cal_addr_n;
         cal_data   <= cal_data_n;
         pkt_err    <= perr_n;
      end
   end

   // Bit-level deserialiser; samples mid-bit, leaves STOP mid stop bit for back-to-back frames
   always_comb begin
      bstate_n = bstate;
      bcnt_n   = bcnt;
      bidx_n   = bidx;
      shift_n  = shift;
      valid_n  = 1'b0;
      ferr_n   = 1'b0;
      data_n   = byte_data;
      case (bstate)
         B_IDLE: begin
            if (!rx) begin
               bstate_n = B_START;
               bcnt_n   = CNT_W'(CLK_DIV / 2 - 1);
            end
         end
         B_START: begin
            if (bcnt != '0) begin
               bcnt_n = bcnt - 1'b1;
            end else if (!rx) begin
               bstate_n = B_DATA;
               bidx_n   = '0;
               bcnt_n   = CNT_W'(CLK_DIV - 1);
            end else begin
               bstate_n = B_IDLE;
            end
         end
         B_DATA: begin
            if (bcnt != '0) begin
               bcnt_n = bcnt - 1'b1;
            end else begin
               shift_n = {rx, shift[7:1]};
               bcnt_n  = CNT_W'(CLK_DIV - 1);
               bidx_n  = bidx + 3'd1;
               if (bidx == 3'd7) bstate_n = B_STOP;
            end
         end
         B_STOP: begin
            if (bcnt != '0) begin
               bcnt_n = bcnt - 1'b1;
            end else if (rx) begin
               valid_n  = 1'b1;
               data_n   = shift;
               bstate_n = B_IDLE;
            end else begin
               ferr_n   = 1'b1;
               bstate_n = B_BREAK;
            end
         end
         B_BREAK: begin
            // A held-low line must return high before a new start bit is accepted
            if (rx) bstate_n = B_IDLE;
         end
         default: bstate_n = B_IDLE;
      endcase
   end

   // Packet decoder with inter-byte timeout
   always_comb begin
      pstate_n   = pstate;
      addr_n     = addr_q;
      dhi_n      = dhi;
      dlo_n      = dlo;
      tcnt_n     = '0;
      we_n       = 1'b0;
      perr_n     = 1'b0;
      cal_addr_n = cal_addr;
      cal_data_n = cal_data;
      if (pstate == P_SYNC) begin
         if (byte_valid && byte_data == SYNC_BYTE) pstate_n = P_ADDR;
      end else if (frame_err) begin
         pstate_n = P_SYNC;
      end else if (byte_valid) begin
         case (pstate)
            P_ADDR: begin
               if (byte_data[7:3] == 5'd0) begin
                  addr_n   = byte_data[2:0];
                  pstate_n = P_DHI;
               end else begin
                  perr_n   = 1'b1;
                  pstate_n = P_SYNC;
               end
            end
            P_DHI: begin
               dhi_n    = byte_data;
               pstate_n = P_DLO;
            end
            P_DLO: begin
               dlo_n    = byte_data;
               pstate_n = P_CSUM;
            end
            P_CSUM: begin
               if (byte_data == ({5'd0, addr_q} ^ dhi ^ dlo)) begin
                  we_n       = 1'b1;
                  cal_addr_n = addr_q;
                  cal_data_n = {dhi, dlo};
               end else begin
                  perr_n = 1'b1;
               end
               pstate_n = P_SYNC;
            end
            default: pstate_n = P_SYNC;
         endcase
      end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
         perr_n   = 1'b1;
         pstate_n = P_SYNC;
      end else begin
         tcnt_n = tcnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cal_uart_rx.sv
// Self-checking bench for cal_uart_rx: scoreboarded bytes/writes, timing, error and abort paths.
`timescale 1ns/100ps
module tb_cal_uart_rx;

   localparam int unsigned CLK_DIV = 12;
   localparam int unsigned TIMEOUT = 12000;
   localparam realtime     BIT     = 120.0;

   logic        clk_12mhz = 1'b0;
   logic        rst = 1'b1;
   logic        rx_i = 1'b1;
   logic        byte_valid, frame_err, cal_we, pkt_err;
   logic [7:0]  byte_data;
   logic [2:0]  cal_addr;
   logic [15:0] cal_data;

   int          n_checks = 0, n_fail = 0;
   int          n_bv = 0, n_ferr = 0, n_perr = 0, n_we = 0;
   longint      cyc = 0, bv_cyc = 0, perr_cyc = 0;
   logic [7:0]  exp_bytes[$];
   logic [18:0] exp_cal[$];

   cal_uart_rx #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .SYNC_BYTE(8'hA5)) dut (
      .clk_12mhz(clk_12mhz), .rst(rst), .rx_i(rx_i),
      .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err),
      .cal_we(cal_we), .cal_addr(cal_addr), .cal_data(cal_data), .pkt_err(pkt_err)
   );

   always #5 clk_12mhz = ~clk_12mhz;
   always @(posedge clk_12mhz) cyc <= cyc + 1;

   // Scoreboard monitor: pops expected bytes/writes as the DUT produces them
   always @(negedge clk_12mhz) begin
      if (!rst) begin
         if (byte_valid) begin
            n_bv++;
            bv_cyc = cyc;
            n_checks++;
            if (exp_bytes.size() == 0) begin
               n_fail++;
               $display("FAIL byte_unexpected: got %02h, required none", byte_data);
            end else begin
               logic [7:0] e;
               e = exp_bytes.pop_front();
               if (byte_data !== e) begin
                  n_fail++;
                  $display("FAIL byte_data: got %02h, required %02h", byte_data, e);
               end
            end
         end
         if (frame_err) n_ferr++;
         if (pkt_err) begin
            n_perr++;
            perr_cyc = cyc;
         end
         if (cal_we) begin
            n_we++;
            n_checks++;
            if (exp_cal.size() == 0) begin
               n_fail++;
               $display("FAIL cal_we_unexpected: got addr %0d data %04h, required none", cal_addr, cal_data);
            end else begin
               logic [18:0] c;
               c = exp_cal.pop_front();
               if ({cal_addr, cal_data} !== c) begin
                  n_fail++;
                  $display("FAIL cal_write: got %0d/%04h, required %0d/%04h", cal_addr, cal_data, c[18:16], c[15:0]);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_12mhz);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input realtime bit_ns);
      if (stop) exp_bytes.push_back(b);
      rx_i = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         #(bit_ns);
      end
      rx_i = stop;
      #(bit_ns);
      rx_i = 1'b1;
   endtask

   // Sends SYNC + 4 bytes; the write is expected only if address and checksum are legal
   task automatic send_pkt(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                           input logic [7:0] c, input realtime bit_ns);
      if (a[7:3] == 5'd0 && c == (a ^ h ^ l)) exp_cal.push_back({a[2:0], h, l});
      send_byte(8'hA5, 1'b1, bit_ns);
      send_byte(a, 1'b1, bit_ns);
      send_byte(h, 1'b1, bit_ns);
      send_byte(l, 1'b1, bit_ns);
      send_byte(c, 1'b1, bit_ns);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx_i = 1'b1;
      idle(3);
      @(negedge clk_12mhz);
      n_checks++;
      if ({byte_valid, frame_err, cal_we, pkt_err} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_strobes: got %b, required 0000", {byte_valid, frame_err, cal_we, pkt_err});
      end
      n_checks++;
      if (byte_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_byte_data: got %02h, required 00", byte_data);
      end
      n_checks++;
      if ({cal_addr, cal_data} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_cal: got %0d/%04h, required 0/0000", cal_addr, cal_data);
      end
      rst = 1'b0;
      idle(5);
   endtask

   task automatic test_single_byte;
      int found, bv0, f0;
      found = 0;
      bv0 = n_bv;
      f0 = n_ferr;
      fork
         send_byte(8'h3C, 1'b1, BIT);
         begin
            for (int i = 1; i <= 140; i++) begin
               @(posedge clk_12mhz);
               @(negedge clk_12mhz);
               if (byte_valid && found == 0) found = i;
            end
         end
      join
      #1;
      // 2 synchroniser cycles + T+115
      n_checks++;
      if (found != 117) begin
         n_fail++;
         $display("FAIL single_latency: got %0d cycles, required 117", found);
      end
      n_checks++;
      if (n_bv - bv0 != 1) begin
         n_fail++;
         $display("FAIL single_count: got %0d pulses, required 1", n_bv - bv0);
      end
      n_checks++;
      if (byte_data !== 8'h3C || n_ferr != f0) begin
         n_fail++;
         $display("FAIL single_data: got %02h ferr %0d, required 3c ferr 0", byte_data, n_ferr - f0);
      end
      idle(10);
   endtask

   task automatic test_good_packet;
      int we0, p0;
      we0 = n_we;
      p0 = n_perr;
      send_pkt(8'h02, 8'h12, 8'h34, 8'h24, BIT);
      idle(30);
      n_checks++;
      if (n_we - we0 != 1 || n_perr != p0) begin
         n_fail++;
         $display("FAIL good_pkt: got we %0d perr %0d, required 1 0", n_we - we0, n_perr - p0);
      end
      n_checks++;
      if (cal_addr !== 3'd2 || cal_data !== 16'h1234) begin
         n_fail++;
         $display("FAIL good_pkt_regs: got %0d/%04h, required 2/1234", cal_addr, cal_data);
      end
   endtask

   task automatic test_bad_csum;
      int we0, p0;
      we0 = n_we;
      p0 = n_perr;
      send_pkt(8'h02, 8'h12, 8'h34, 8'h25, BIT);
      idle(30);
      n_checks++;
      if (n_we != we0 || n_perr - p0 != 1) begin
         n_fail++;
         $display("FAIL bad_csum: got we %0d perr %0d, required 0 1", n_we - we0, n_perr - p0);
      end
      n_checks++;
      if (cal_addr !== 3'd2 || cal_data !== 16'h1234) begin
         n_fail++;
         $display("FAIL bad_csum_hold: got %0d/%04h, required 2/1234", cal_addr, cal_data);
      end
      send_pkt(8'h05, 8'hAB, 8'hCD, 8'h63, BIT);
      idle(30);
      n_checks++;
      if (n_we - we0 != 1 || cal_data !== 16'hABCD) begin
         n_fail++;
         $display("FAIL csum_recover: got we %0d data %04h, required 1 abcd", n_we - we0, cal_data);
      end
   endtask

   task automatic test_bad_addr;
      int we0, p0;
      we0 = n_we;
      p0 = n_perr;
      send_byte(8'hA5, 1'b1, BIT);
      send_byte(8'h09, 1'b1, BIT);
      idle(20);
      n_checks++;
      if (n_perr - p0 != 1) begin
         n_fail++;
         $display("FAIL bad_addr: got perr %0d, required 1", n_perr - p0);
      end
      send_pkt(8'h01, 8'hFF, 8'hFF, 8'h01, BIT);
      idle(30);
      n_checks++;
      if (n_we - we0 != 1 || cal_addr !== 3'd1 || cal_data !== 16'hFFFF || n_perr - p0 != 1) begin
         n_fail++;
         $display("FAIL addr_recover: got we %0d %0d/%04h perr %0d, required 1 1/ffff 1",
                  n_we - we0, cal_addr, cal_data, n_perr - p0);
      end
   endtask

   task automatic test_frame_err;
      int we0, p0, f0;
      we0 = n_we;
      p0 = n_perr;
      f0 = n_ferr;
      send_byte(8'hA5, 1'b1, BIT);
      send_byte(8'h02, 1'b1, BIT);
      send_byte(8'h12, 1'b0, BIT);
      idle(30);
      n_checks++;
      if (n_ferr - f0 != 1 || n_perr != p0 || n_we != we0) begin
         n_fail++;
         $display("FAIL frame_err: got ferr %0d perr %0d we %0d, required 1 0 0", n_ferr - f0, n_perr - p0, n_we - we0);
      end
      n_checks++;
      if (byte_data !== 8'h02) begin
         n_fail++;
         $display("FAIL frame_err_hold: got %02h, required 02", byte_data);
      end
      send_pkt(8'h03, 8'h55, 8'hAA, 8'hFC, BIT);
      idle(30);
      n_checks++;
      if (n_we - we0 != 1 || cal_data !== 16'h55AA) begin
         n_fail++;
         $display("FAIL ferr_recover: got we %0d data %04h, required 1 55aa", n_we - we0, cal_data);
      end
   endtask

   task automatic test_glitch_and_break;
      int bv0, f0;
      bv0 = n_bv;
      f0 = n_ferr;
      rx_i = 1'b0;
      idle(2);
      rx_i = 1'b1;
      idle(200);
      n_checks++;
      if (n_bv != bv0 || n_ferr != f0) begin
         n_fail++;
         $display("FAIL glitch: got bv %0d ferr %0d, required 0 0", n_bv - bv0, n_ferr - f0);
      end
      rx_i = 1'b0;
      idle(400);
      n_checks++;
      if (n_ferr - f0 != 1 || n_bv != bv0) begin
         n_fail++;
         $display("FAIL break: got ferr %0d bv %0d, required 1 0", n_ferr - f0, n_bv - bv0);
      end
      rx_i = 1'b1;
      idle(5);
      send_byte(8'h5A, 1'b1, BIT);
      idle(20);
      n_checks++;
      if (n_bv - bv0 != 1) begin
         n_fail++;
         $display("FAIL break_recover: got bv %0d, required 1", n_bv - bv0);
      end
   endtask

   task automatic test_timeout;
      int we0, p0;
      we0 = n_we;
      p0 = n_perr;
      send_byte(8'hA5, 1'b1, BIT);
      send_byte(8'h03, 1'b1, BIT);
      idle(TIMEOUT + 50);
      n_checks++;
      if (n_perr - p0 != 1) begin
         n_fail++;
         $display("FAIL timeout: got perr %0d, required 1", n_perr - p0);
      end
      n_checks++;
      if (perr_cyc - bv_cyc != longint'(TIMEOUT + 1)) begin
         n_fail++;
         $display("FAIL timeout_delay: got %0d cycles, required %0d", perr_cyc - bv_cyc, TIMEOUT + 1);
      end
      send_byte(8'h12, 1'b1, BIT);
      send_byte(8'h34, 1'b1, BIT);
      send_byte(8'h26, 1'b1, BIT);
      idle(30);
      n_checks++;
      if (n_we != we0 || n_perr - p0 != 1) begin
         n_fail++;
         $display("FAIL post_timeout: got we %0d perr %0d, required 0 1", n_we - we0, n_perr - p0);
      end
   endtask

   task automatic test_back_to_back;
      int we0, bv0;
      logic [7:0] r;
      we0 = n_we;
      send_pkt(8'h00, 8'hA5, 8'hA5, 8'h00, BIT);
      idle(30);
      n_checks++;
      if (n_we - we0 != 1 || cal_addr !== 3'd0 || cal_data !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL sync_as_data: got we %0d %0d/%04h, required 1 0/a5a5", n_we - we0, cal_addr, cal_data);
      end
      bv0 = n_bv;
      for (int i = 0; i < 16; i++) begin
         r = 8'($urandom_range(0, 255));
         if (r == 8'hA5) r = 8'h5A;
         send_byte(r, 1'b1, BIT);
      end
      idle(30);
      n_checks++;
      if (n_bv - bv0 != 16 || exp_bytes.size() != 0) begin
         n_fail++;
         $display("FAIL back_to_back: got %0d bytes, %0d pending, required 16 0", n_bv - bv0, exp_bytes.size());
      end
   endtask

   task automatic test_baud_error;
      int we0;
      we0 = n_we;
      send_pkt(8'h06, 8'h0F, 8'hF0, 8'hF9, BIT * 0.97);
      idle(30);
      send_pkt(8'h07, 8'hC3, 8'h3C, 8'hF8, BIT * 1.03);
      idle(30);
      n_checks++;
      if (n_we - we0 != 2 || cal_data !== 16'hC33C || exp_bytes.size() != 0) begin
         n_fail++;
         $display("FAIL baud_tol: got we %0d data %04h pending %0d, required 2 c33c 0",
                  n_we - we0, cal_data, exp_bytes.size());
      end
   endtask

   task automatic test_reset_mid;
      int we0;
      send_byte(8'hA5, 1'b1, BIT);
      send_byte(8'h02, 1'b1, BIT);
      rx_i = 1'b0;
      idle(60);
      rst = 1'b1;
      @(negedge clk_12mhz);
      n_checks++;
      if ({byte_valid, byte_data, frame_err, cal_we, cal_addr, cal_data, pkt_err} !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got bd %02h cal %0d/%04h, required all zero", byte_data, cal_addr, cal_data);
      end
      rx_i = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(5);
      we0 = n_we;
      send_byte(8'h12, 1'b1, BIT);
      send_byte(8'h34, 1'b1, BIT);
      send_byte(8'h24, 1'b1, BIT);
      idle(30);
      n_checks++;
      if (n_we != we0) begin
         n_fail++;
         $display("FAIL reset_pkt_state: got we %0d, required 0", n_we - we0);
      end
      send_pkt(8'h04, 8'h00, 8'h01, 8'h05, BIT);
      idle(30);
      n_checks++;
      if (n_we - we0 != 1 || cal_addr !== 3'd4 || cal_data !== 16'h0001) begin
         n_fail++;
         $display("FAIL reset_recover: got we %0d %0d/%04h, required 1 4/0001", n_we - we0, cal_addr, cal_data);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_good_packet();
      test_bad_csum();
      test_bad_addr();
      test_frame_err();
      test_glitch_and_break();
      test_timeout();
      test_back_to_back();
      test_baud_error();
      test_reset_mid();
      n_checks++;
      if (exp_bytes.size() != 0 || exp_cal.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d bytes %0d writes pending, required 0 0",
                  exp_bytes.size(), exp_cal.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
